// File: rtl/clk_rst_seq.sv
// Reset sequencer for the clock-generator output side.
// Waits for MMCM lock to be stable, releases peripheral reset, then CPU reset
// after a gap. Loss of lock or a button press re-asserts both resets.
// Runs on the free-running board clock so it keeps working while unlocked.
//
// Ports:
//   clk           board clock (free-running)
//   rst_n         synchronous active-low reset
//   locked_in     MMCM lock status (asynchronous)
//   rst_btn       board reset button, active-high (asynchronous)
//   rst_periph_n  peripheral reset, active-low, registered
//   rst_cpu_n     CPU reset, active-low, registered
//   sys_ready     high only in RUN, registered
//   lock_lost_cnt saturating count of lock-loss events
//   state         current FSM state for debug
module clk_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       rst_btn,
  output logic       rst_periph_n,
  output logic       rst_cpu_n,
  output logic       sys_ready,
  output logic [7:0] lock_lost_cnt,
  output logic [1:0] state
);

  localparam int unsigned MAX_CYC = (LOCK_STABLE_CYCLES > STAGE_GAP) ?
                                    LOCK_STABLE_CYCLES : STAGE_GAP;
  // Keep at least one bit so a 1-cycle configuration still elaborates.
  localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [7:0]       LLC_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABLE     = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } state_e;

  logic             lock_meta_q, lock_meta_d;
  logic             locked_s_q, locked_s_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_periph_n_q, rst_periph_n_d;
  logic             rst_cpu_n_q, rst_cpu_n_d;
  logic             sys_ready_q, sys_ready_d;
  logic [7:0]       lock_lost_cnt_q, lock_lost_cnt_d;
  logic             abort_c;

  // Two-flop synchronizers for the asynchronous inputs.
  always_comb begin
    lock_meta_d = locked_in;
    locked_s_d  = lock_meta_q;
    btn_meta_d  = rst_btn;
    btn_s_d     = btn_meta_q;
  end

  assign abort_c = !locked_s_q || btn_s_q;

  // Next state, stage counter and registered output values.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    lock_lost_cnt_d = lock_lost_cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!abort_c) state_d = STABLE;
      end
      STABLE: begin
        if (abort_c)                 state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = REL_PERIPH;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      REL_PERIPH: begin
        if (abort_c)                state_d = WAIT_LOCK;
        else if (cnt_q == GAP_LAST) state_d = RUN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (abort_c) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Every state change restarts the stage counter.
    if (state_d != state_q) cnt_d = '0;

    // Outputs follow the state being entered so they change on the same edge.
    rst_periph_n_d = (state_d == REL_PERIPH) || (state_d == RUN);
    rst_cpu_n_d    = (state_d == RUN);
    sys_ready_d    = (state_d == RUN);

    // Only lock loss outside WAIT_LOCK counts; button-only aborts do not.
    if ((state_q != WAIT_LOCK) && !locked_s_q && (lock_lost_cnt_q != LLC_MAX))
      lock_lost_cnt_d = lock_lost_cnt_q + 8'd1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_q     <= 1'b0;
      locked_s_q      <= 1'b0;
      btn_meta_q      <= 1'b0;
      btn_s_q         <= 1'b0;
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      rst_periph_n_q  <= 1'b0;
      rst_cpu_n_q     <= 1'b0;
      sys_ready_q     <= 1'b0;
      lock_lost_cnt_q <= 8'd0;
    end else begin
      lock_meta_q     <= lock_meta_d;
      locked_s_q      <= locked_s_d;
      btn_meta_q      <= btn_meta_d;
      btn_s_q         <= btn_s_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rst_periph_n_q  <= rst_periph_n_d;
      rst_cpu_n_q     <= rst_cpu_n_d;
      sys_ready_q     <= sys_ready_d;
      lock_lost_cnt_q <= lock_lost_cnt_d;
    end
  end

  assign rst_periph_n  = rst_periph_n_q;
  assign rst_cpu_n     = rst_cpu_n_q;
  assign sys_ready     = sys_ready_q;
  assign lock_lost_cnt = lock_lost_cnt_q;
  assign state         = state_q;

endmodule
